piece_motion_scheduler: RTL and testbench
=========================================

// Module: piece_motion_scheduler
// PURPOSE
//  Sequences motion of the falling 2x3 red piece drawn by the VGA controller: produces the
//  X/Y offsets (iXRedCounter/iYRedCounter) once per video frame, arbitrating gravity drops
//  against player left/right/down requests. Updates only at frame start (vsync falling
//  edge) so a frame never shows a half-moved piece. Runs on the 25 MHz pixel clock.
// PARAMETERS
//  STEP            32   pixels moved per accepted move (one grid cell)
//  X_INIT          96   X offset at spawn; multiple of STEP
//  X_MAX           192  largest legal X offset; multiple of STEP
//  Y_MAX           96   largest legal Y offset (landing row); multiple of STEP
//  FRAMES_PER_DROP 30   frames between gravity drops, >=2 (30 -> 0.5 s at 60 Hz)
// PORTS
//  Clock     in   1   pixel clock; all logic on posedge
//  Reset     in   1   synchronous, active-high
//  iVsync    in   1   oVsync of VGA controller (active-low pulse)
//  iStart    in   1   level; spawns a new piece when sampled high in IDLE/LANDED
//  iBtnLeft  in   1   raw button, asynchronous to Clock
//  iBtnRight in   1   raw button, asynchronous to Clock
//  iBtnDown  in   1   raw button, asynchronous to Clock
//  oXOffset  out  10  piece X offset -> iXRedCounter
//  oYOffset  out  10  piece Y offset -> iYRedCounter
//  oLanded   out  1   high while state is LANDED
//  oFrame    out  1   one-cycle strobe at each frame start (debug/test)
// BEHAVIOUR
//  Reset: oXOffset=X_INIT, oYOffset=0, oLanded=0, oFrame=0, state IDLE, frame counter 0,
//   all pending flags 0, synchronizer flops 0 (iVsync sync flops reset to 1).
//  Inputs: iVsync and each button pass a 2-flop synchronizer. oFrame = synced iVsync
//   1->0 transition, registered: asserts 3 cycles after raw iVsync falls. Button rising
//   edge (synced) sets its sticky pending flag; re-press while pending has no extra effect.
//  FSM:
//   IDLE    : offsets held. iStart=1 -> FALLING; X=X_INIT, Y=0, counter=0, pendings cleared.
//   FALLING : counter increments on each oFrame; gravity due on oFrame when counter ==
//             FRAMES_PER_DROP-1 (counter -> 0). On each oFrame exactly one action, priority:
//             1) gravity due: Y<Y_MAX -> Y+=STEP; Y==Y_MAX -> LANDED (Y unchanged)
//             2) down pending: same rule as gravity; counter -> 0 if moved; flag cleared
//             3) left+right both pending: both cleared, no move
//             4) left pending: X>0 -> X-=STEP; flag cleared either way
//             5) right pending: X<X_MAX -> X+=STEP; flag cleared either way
//             Lower-priority pendings not serviced stay set for a later frame.
//   LANDED  : oLanded=1, offsets frozen, button edges ignored and pendings cleared.
//             iStart=1 -> respawn exactly as from IDLE (oLanded falls next cycle).
//  Offsets change only in the cycle after oFrame (1-cycle latency), or on spawn.
//  Button edge and oFrame same cycle: edge is registered but serviced next frame.
//  Reset mid-motion: returns to reset values next cycle, regardless of state.
//  Arithmetic 10-bit unsigned; parameter legality guarantees no wrap.
// TESTING
//  1 Reset, iStart pulse, 5 frames no buttons -> X=96,Y=0; frame 30 -> Y=32; frame 60 -> Y=64.
//  2 FALLING, press Left once -> next oFrame X=64; 3 more presses -> X=0, 4th press X stays 0.
//  3 Left and Right rise before same oFrame -> X unchanged, both flags clear.
//  4 Gravity due and Down+Left pending same frame -> Y+=32 only; Down next frame, Left after.
//  5 Y=96 and gravity due -> LANDED, oLanded=1, Y=96; buttons ignored; iStart -> X=96,Y=0.
//  6 Reset asserted at X=160,Y=64 mid-frame -> next cycle X=96,Y=0, IDLE, oLanded=0.

Source files
------------

// File: rtl/piece_motion_scheduler.sv
// Frame-synchronous motion sequencer for the falling 2x3 piece: gravity drops plus player moves.
// Offsets update one cycle after the oFrame strobe; button presses are held pending until serviced.
module piece_motion_scheduler #(
  parameter int STEP            = 32,
  parameter int X_INIT          = 96,
  parameter int X_MAX           = 192,
  parameter int Y_MAX           = 96,
  parameter int FRAMES_PER_DROP = 30
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iVsync,
  input  logic       iStart,
  input  logic       iBtnLeft,
  input  logic       iBtnRight,
  input  logic       iBtnDown,
  output logic [9:0] oXOffset,
  output logic [9:0] oYOffset,
  output logic       oLanded,
  output logic       oFrame
);

  localparam int CW = (FRAMES_PER_DROP > 2) ? $clog2(FRAMES_PER_DROP) : 1;
  localparam logic [9:0]    STEP_W   = 10'(STEP);
  localparam logic [9:0]    X_INIT_W = 10'(X_INIT);
  localparam logic [9:0]    X_MAX_W  = 10'(X_MAX);
  localparam logic [9:0]    Y_MAX_W  = 10'(Y_MAX);
  localparam logic [CW-1:0] DROP_DUE = CW'(FRAMES_PER_DROP - 1);

  typedef enum logic [1:0] {IDLE, FALLING, LANDED} state_t;

  // button vectors are ordered {down, right, left}
  logic       vs_s1, vs_s2, vs_d;
  logic [2:0] btn_s1, btn_s2, btn_d;
  logic [2:0] btn_rise;

  state_t        state;
  logic [CW-1:0] drop_cnt;
  logic          pend_left, pend_right, pend_down;

  assign btn_rise = btn_s2 & ~btn_d;

  // vsync idles high, so its synchronizer resets high to avoid a spurious frame strobe
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vs_s1  <= 1'b1;
      vs_s2  <= 1'b1;
      vs_d   <= 1'b1;
      btn_s1 <= 3'b000;
      btn_s2 <= 3'b000;
      btn_d  <= 3'b000;
      oFrame <= 1'b0;
    end else begin
      vs_s1  <= iVsync;
      vs_s2  <= vs_s1;
      vs_d   <= vs_s2;
      btn_s1 <= {iBtnDown, iBtnRight, iBtnLeft};
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
      oFrame <= vs_d & ~vs_s2;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      oXOffset   <= X_INIT_W;
      oYOffset   <= 10'd0;
      oLanded    <= 1'b0;
      drop_cnt   <= '0;
      pend_left  <= 1'b0;
      pend_right <= 1'b0;
      pend_down  <= 1'b0;
    end else begin
      case (state)
        IDLE, LANDED: begin
          pend_left  <= 1'b0;
          pend_right <= 1'b0;
          pend_down  <= 1'b0;
          if (iStart) begin
            state    <= FALLING;
            oXOffset <= X_INIT_W;
            oYOffset <= 10'd0;
            oLanded  <= 1'b0;
            drop_cnt <= '0;
          end
        end

        FALLING: begin
          if (oFrame) begin
            if (drop_cnt == DROP_DUE) begin
              drop_cnt <= '0;
              if (oYOffset < Y_MAX_W) begin
                oYOffset <= oYOffset + STEP_W;
              end else begin
                state   <= LANDED;
                oLanded <= 1'b1;
              end
            end else begin
              drop_cnt <= drop_cnt + CW'(1);
              if (pend_down) begin
                pend_down <= 1'b0;
                if (oYOffset < Y_MAX_W) begin
                  oYOffset <= oYOffset + STEP_W;
                  drop_cnt <= '0;
                end else begin
                  state   <= LANDED;
                  oLanded <= 1'b1;
                end
              end else if (pend_left && pend_right) begin
                pend_left  <= 1'b0;
                pend_right <= 1'b0;
              end else if (pend_left) begin
                pend_left <= 1'b0;
                if (oXOffset > 10'd0) oXOffset <= oXOffset - STEP_W;
              end else if (pend_right) begin
                pend_right <= 1'b0;
                if (oXOffset < X_MAX_W) oXOffset <= oXOffset + STEP_W;
              end
            end
          end
          // a fresh edge wins over a same-cycle service clear; it is handled next frame
          if (btn_rise[0]) pend_left  <= 1'b1;
          if (btn_rise[1]) pend_right <= 1'b1;
          if (btn_rise[2]) pend_down  <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_motion_scheduler.sv
// Directed bench for piece_motion_scheduler: gravity timing, player moves, priority, landing, reset.
module tb_piece_motion_scheduler;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iVsync = 1'b1;
  logic       iStart = 1'b0;
  logic       iBtnLeft = 1'b0;
  logic       iBtnRight = 1'b0;
  logic       iBtnDown = 1'b0;
  logic [9:0] oXOffset, oYOffset;
  logic       oLanded, oFrame;

  int n_checks = 0;
  int n_errors = 0;

  piece_motion_scheduler dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .iVsync   (iVsync),
    .iStart   (iStart),
    .iBtnLeft (iBtnLeft),
    .iBtnRight(iBtnRight),
    .iBtnDown (iBtnDown),
    .oXOffset (oXOffset),
    .oYOffset (oYOffset),
    .oLanded  (oLanded),
    .oFrame   (oFrame)
  );

  always #20 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // one vsync pulse; returns once the offset update following oFrame is visible
  task automatic frame();
    int waited = 0;
    @(negedge Clock);
    iVsync = 1'b0;
    while (oFrame !== 1'b1 && waited < 10) begin
      @(negedge Clock);
      waited++;
    end
    if (oFrame !== 1'b1) check("frame_timeout", 32'(oFrame), 32'd1);
    @(negedge Clock);
    iVsync = 1'b1;
    cycles(5);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic press(input logic l, input logic r, input logic d);
    @(negedge Clock);
    iBtnLeft = l; iBtnRight = r; iBtnDown = d;
    cycles(4);
    iBtnLeft = 1'b0; iBtnRight = 1'b0; iBtnDown = 1'b0;
    cycles(4);
  endtask

  task automatic do_reset_spawn();
    @(negedge Clock);
    Reset = 1'b1;
    cycles(2);
    Reset = 1'b0;
    iStart = 1'b1;
    cycles(1);
    iStart = 1'b0;
    cycles(1);
  endtask

  task automatic check_pos(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(oXOffset), 32'(x));
    check({tag, "_y"}, 32'(oYOffset), 32'(y));
  endtask

  initial begin
    cycles(3);
    check("rst_x", 32'(oXOffset), 32'd96);
    check("rst_y", 32'(oYOffset), 32'd0);
    check("rst_landed", 32'(oLanded), 32'd0);
    check("rst_frame", 32'(oFrame), 32'd0);

    // oFrame latency: high exactly on the 3rd cycle after vsync falls
    Reset = 1'b0;
    @(negedge Clock);
    iVsync = 1'b0;
    cycles(2);
    check("frame_lat2", 32'(oFrame), 32'd0);
    cycles(1);
    check("frame_lat3", 32'(oFrame), 32'd1);
    cycles(1);
    check("frame_pulse", 32'(oFrame), 32'd0);
    iVsync = 1'b1;
    cycles(5);

    // IDLE ignores frames and buttons
    press(1'b1, 1'b0, 1'b0);
    frame();
    check_pos("idle", 96, 0);

    // 1: gravity every 30 frames
    do_reset_spawn();
    frames(5);
    check_pos("t1_f5", 96, 0);
    frames(24);
    check_pos("t1_f29", 96, 0);
    frame();
    check_pos("t1_f30", 96, 32);
    frames(30);
    check_pos("t1_f60", 96, 64);

    // 2: left moves down to the wall
    press(1'b1, 1'b0, 1'b0); frame(); check_pos("t2_l1", 64, 64);
    press(1'b1, 1'b0, 1'b0); frame(); check("t2_l2", 32'(oXOffset), 32'd32);
    press(1'b1, 1'b0, 1'b0); frame(); check("t2_l3", 32'(oXOffset), 32'd0);
    press(1'b1, 1'b0, 1'b0); frame(); check("t2_l4_wall", 32'(oXOffset), 32'd0);
    frame();
    check("t2_no_extra", 32'(oXOffset), 32'd0);

    // 3: simultaneous left+right cancels
    press(1'b0, 1'b1, 1'b0); frame(); check("t3_r", 32'(oXOffset), 32'd32);
    press(1'b1, 1'b1, 1'b0); frame(); check("t3_lr", 32'(oXOffset), 32'd32);
    frame();
    check_pos("t3_cleared", 32, 64);

    // 4: gravity beats down beats left
    do_reset_spawn();
    frames(29);
    press(1'b1, 1'b0, 1'b1);
    frame(); check_pos("t4_grav", 96, 32);
    frame(); check_pos("t4_down", 96, 64);
    frame(); check_pos("t4_left", 64, 64);

    // 5: landing at the bottom row (down reset the gravity counter)
    press(1'b0, 1'b0, 1'b1);
    frame(); check_pos("t5_down", 64, 96);
    frames(29);
    check("t5_not_yet", 32'(oLanded), 32'd0);
    frame();
    check("t5_landed", 32'(oLanded), 32'd1);
    check_pos("t5_land", 64, 96);
    press(1'b0, 1'b1, 1'b0);
    frame();
    check_pos("t5_frozen", 64, 96);
    @(negedge Clock);
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
    check("t5_respawn_landed", 32'(oLanded), 32'd0);
    check_pos("t5_respawn", 96, 0);
    frame();
    check_pos("t5_pend_cleared", 96, 0);

    // 6: reset mid-motion
    press(1'b0, 1'b1, 1'b0); frame();
    press(1'b0, 1'b1, 1'b0); frame();
    press(1'b0, 1'b0, 1'b1); frame();
    press(1'b0, 1'b0, 1'b1); frame();
    check_pos("t6_pre", 160, 64);
    @(negedge Clock);
    iVsync = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check_pos("t6_rst", 96, 0);
    check("t6_rst_landed", 32'(oLanded), 32'd0);
    Reset = 1'b0;
    iVsync = 1'b1;
    cycles(5);
    press(1'b0, 1'b0, 1'b1);
    frame();
    check_pos("t6_idle", 96, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
